// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the writeback stage
package arm_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } mem_size_t;
  typedef enum logic {
    IDLE,
    WAIT_MEM
  } wb_state_t;
  typedef struct packed {
    logic [1:0] off;
    logic [3:0] wa3;
    logic       regWrite;
    logic       pcSrc;
    logic [1:0] size;
    logic       loadSigned;
  } pend_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed half/byte of a read word and zero/sign-extends it
module load_align
  import arm_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              loadSigned,
  output logic [DATA_W-1:0] result
);
  logic [15:0] halfVal;
  logic [7:0]  byteVal;
  always_comb begin
    halfVal = data[{off[1], 4'b0} +: 16];
    byteVal = data[{off, 3'b0} +: 8];
    result  = size == MEM_HALF ? {{16{loadSigned & halfVal[15]}}, halfVal}
            : size == MEM_BYTE ? {{24{loadSigned & byteVal[7]}}, byteVal} : data;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: memory->writeback register with load-return wait, alignment and timeout
module writeback_stage
  import arm_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ValidM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [3:0]        WA3M,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              PCSrcM,
  input  logic [1:0]        MemSizeM,
  input  logic              LoadSignedM,
  input  logic              FlushW,
  input  logic              MemRValid,
  input  logic [DATA_W-1:0] MemRData,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [3:0]        WA3W,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCSrcW,
  output logic              LoadTimeout
);
  localparam int CW = $clog2(TIMEOUT);
  wb_state_t         state, nextState;
  logic [CW-1:0]     cnt;
  pend_t             pend;
  logic              inWait, lastWait, goWait, retire, timeoutNow;
  logic              retRegWrite, retPcSrc, alSigned;
  logic [3:0]        retWa3;
  logic [1:0]        alOff, alSize;
  logic [DATA_W-1:0] aligned, retData;

  load_align uAlign (
    .data      (MemRData),
    .off       (alOff),
    .size      (alSize),
    .loadSigned(alSigned),
    .result    (aligned)
  );

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state <= IDLE;
    else state <= nextState;

  // A pending load uses the latched request; otherwise the live memory-stage inputs
  always_comb begin
    inWait      = state == WAIT_MEM;
    lastWait    = cnt == CW'(TIMEOUT - 1);
    goWait      = !inWait && ValidM && MemToRegM && !MemRValid && !FlushW;
    StallM      = Rst && (goWait || (inWait && !FlushW && !MemRValid && !lastWait));
    nextState   = StallM ? WAIT_MEM : IDLE;
    retire      = !FlushW && (inWait ? MemRValid : ValidM && (!MemToRegM || MemRValid));
    timeoutNow  = inWait && !FlushW && !MemRValid && lastWait;
    alOff       = inWait ? pend.off : ALUResultM[1:0];
    alSize      = inWait ? pend.size : MemSizeM;
    alSigned    = inWait ? pend.loadSigned : LoadSignedM;
    retRegWrite = inWait ? pend.regWrite : RegWriteM;
    retPcSrc    = inWait ? pend.pcSrc : PCSrcM;
    retWa3      = inWait ? pend.wa3 : WA3M;
    retData     = !inWait && !MemToRegM ? ALUResultM : aligned;
  end

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      cnt         <= '0;
      pend        <= '0;
      RegWriteW   <= 1'b0;
      PCSrcW      <= 1'b0;
      WA3W        <= '0;
      ResultW     <= '0;
      LoadTimeout <= 1'b0;
    end else begin
      cnt       <= inWait && nextState == WAIT_MEM ? cnt + 1'b1 : '0;
      RegWriteW <= retire && retRegWrite;
      PCSrcW    <= retire && retPcSrc;
      if (goWait) pend <= '{ALUResultM[1:0], WA3M, RegWriteM, PCSrcM, MemSizeM, LoadSignedM};
      if (retire) begin
        WA3W    <= retWa3;
        ResultW <= retData;
      end
      if (timeoutNow) LoadTimeout <= 1'b1;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed, table-driven and randomized checks of the writeback stage
module tb_writeback_stage;
  localparam int TO = 16;
  logic        Clk = 1'b0, Rst = 1'b0;
  logic        ValidM, RegWriteM, MemToRegM, PCSrcM, LoadSignedM, FlushW, MemRValid;
  logic [31:0] ALUResultM, MemRData, ResultW;
  logic [3:0]  WA3M, WA3W;
  logic [1:0]  MemSizeM;
  logic        StallM, RegWriteW, PCSrcW, LoadTimeout;
  logic [31:0] alData, alRes;
  logic [1:0]  alOff, alSize;
  logic        alSgn;
  int          tests = 0, fails = 0, n;

  always #5 Clk = ~Clk;

  writeback_stage #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .ValidM(ValidM), .ALUResultM(ALUResultM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .PCSrcM(PCSrcM), .MemSizeM(MemSizeM),
    .LoadSignedM(LoadSignedM), .FlushW(FlushW), .MemRValid(MemRValid), .MemRData(MemRData),
    .StallM(StallM), .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
    .PCSrcW(PCSrcW), .LoadTimeout(LoadTimeout)
  );

  load_align ua (.data(alData), .off(alOff), .size(alSize), .loadSigned(alSgn), .result(alRes));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp;
  } alVec_t;
  alVec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] wa, input logic rw,
                       input logic m2r, input logic pcs, input logic [1:0] sz, input logic sg);
    ValidM = v; ALUResultM = alu; WA3M = wa; RegWriteM = rw;
    MemToRegM = m2r; PCSrcM = pcs; MemSizeM = sz; LoadSignedM = sg;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    FlushW = 1'b0; MemRValid = 1'b0; MemRData = 32'h0;
  endtask

  function automatic logic [31:0] refAlign(logic [31:0] d, logic [1:0] off, logic [1:0] sz, logic sg);
    logic [31:0] v;
    if (sz == 2'd1) begin
      v = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (sz == 2'd2) begin
      v = (d >> (int'(off) * 8)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else v = d;
    return v;
  endfunction

  bit          pend, eStall;
  int          waited;
  logic [1:0]  pOff, pSz;
  logic        pSg, pRw, pPc, eRw, ePc, eTo;
  logic [3:0]  pWa, eWa;
  logic [31:0] eRes;

  task automatic retireTo(input logic rw, input logic pc, input logic [3:0] wa, input logic [31:0] r);
    eRw = rw; ePc = pc; eWa = wa; eRes = r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h1122_3344, 2'd0, 2'd0, 1'b0, 32'h1122_3344};
    vecs[1]  = '{32'h1122_3344, 2'd1, 2'd3, 1'b1, 32'h1122_3344};
    vecs[2]  = '{32'h0080_0000, 2'd2, 2'd2, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{32'h0080_0000, 2'd2, 2'd2, 1'b0, 32'h0000_0080};
    vecs[4]  = '{32'hBEEF_0000, 2'd2, 2'd1, 1'b0, 32'h0000_BEEF};
    vecs[5]  = '{32'hBEEF_0000, 2'd2, 2'd1, 1'b1, 32'hFFFF_BEEF};
    vecs[6]  = '{32'hBEEF_0000, 2'd3, 2'd1, 1'b0, 32'h0000_BEEF};
    vecs[7]  = '{32'h1234_8765, 2'd1, 2'd1, 1'b1, 32'hFFFF_8765};
    vecs[8]  = '{32'h1234_8765, 2'd1, 2'd2, 1'b1, 32'hFFFF_FF87};
    vecs[9]  = '{32'h1234_8765, 2'd3, 2'd2, 1'b1, 32'h0000_0012};
    vecs[10] = '{32'h1234_8765, 2'd0, 2'd2, 1'b0, 32'h0000_0065};
    idle();
    repeat (2) @(negedge Clk);
    chk("rstStall", 32'(StallM), 32'h0);
    chk("rstRegWrite", 32'(RegWriteW), 32'h0);
    chk("rstPCSrc", 32'(PCSrcW), 32'h0);
    chk("rstWA3", 32'(WA3W), 32'h0);
    chk("rstResult", ResultW, 32'h0);
    chk("rstTimeout", 32'(LoadTimeout), 32'h0);
    drive(1'b1, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    #1 chk("rstStallGated", 32'(StallM), 32'h0);
    idle();
    for (int i = 0; i < 11; i++) begin
      alData = vecs[i].data; alOff = vecs[i].off; alSize = vecs[i].size; alSgn = vecs[i].sgn;
      #1 chk($sformatf("align%0d", i), alRes, vecs[i].exp);
    end
    @(negedge Clk); Rst = 1'b1;
    // ALU op retires one cycle later
    @(negedge Clk); drive(1'b1, 32'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    #1 chk("aluStall", 32'(StallM), 32'h0);
    @(negedge Clk); idle();
    chk("aluRegWrite", 32'(RegWriteW), 32'h1);
    chk("aluWA3", 32'(WA3W), 32'h3);
    chk("aluResult", ResultW, 32'h1234);
    @(negedge Clk);
    chk("aluPulse", 32'(RegWriteW), 32'h0);
    chk("aluHold", ResultW, 32'h1234);
    // signed byte load, data three cycles late
    @(negedge Clk); drive(1'b1, 32'h2002, 4'd5, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1 if (StallM) n++; else break;
      @(negedge Clk);
      if (n == 3) begin MemRValid = 1'b1; MemRData = 32'h0080_0000; end
    end
    chk("sbStallCycles", n, 32'd3);
    @(negedge Clk); idle();
    chk("sbRegWrite", 32'(RegWriteW), 32'h1);
    chk("sbWA3", 32'(WA3W), 32'h5);
    chk("sbResult", ResultW, 32'hFFFF_FF80);
    // unsigned half, same-cycle data
    @(negedge Clk); drive(1'b1, 32'h3002, 4'd6, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    MemRValid = 1'b1; MemRData = 32'hBEEF_0000;
    #1 chk("uhStall", 32'(StallM), 32'h0);
    @(negedge Clk); idle();
    chk("uhResult", ResultW, 32'h0000_BEEF);
    chk("uhWA3", 32'(WA3W), 32'h6);
    // load to R15 redirects
    @(negedge Clk); drive(1'b1, 32'h1000, 4'd15, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    MemRValid = 1'b1; MemRData = 32'h100;
    @(negedge Clk); idle();
    chk("pcPCSrc", 32'(PCSrcW), 32'h1);
    chk("pcRegWrite", 32'(RegWriteW), 32'h1);
    chk("pcResult", ResultW, 32'h100);
    chk("pcWA3", 32'(WA3W), 32'hF);
    @(negedge Clk);
    chk("pcPulse", 32'(PCSrcW), 32'h0);
    // timeout
    @(negedge Clk); drive(1'b1, 32'h4000, 4'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1 if (StallM) n++; else break;
      @(negedge Clk);
    end
    chk("toStallCycles", n, 32'd16);
    chk("toNotYet", 32'(LoadTimeout), 32'h0);
    @(negedge Clk); idle();
    chk("toSticky", 32'(LoadTimeout), 32'h1);
    chk("toNoWrite", 32'(RegWriteW), 32'h0);
    // flush beats MemRValid in WAIT_MEM
    @(negedge Clk); drive(1'b1, 32'h5000, 4'd8, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    #1 chk("flStall", 32'(StallM), 32'h1);
    @(negedge Clk); MemRValid = 1'b1; FlushW = 1'b1; MemRData = 32'hDEAD;
    #1 chk("flStallDrop", 32'(StallM), 32'h0);
    @(negedge Clk); idle();
    chk("flNoWrite", 32'(RegWriteW), 32'h0);
    chk("flHold", ResultW, 32'h100);
    drive(1'b1, 32'h77, 4'd9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    #1 chk("flIdleStall", 32'(StallM), 32'h0);
    @(negedge Clk); idle();
    chk("flIdleRetire", ResultW, 32'h77);
    chk("flStickyTimeout", 32'(LoadTimeout), 32'h1);
    // reset mid-wait
    @(negedge Clk); drive(1'b1, 32'h6000, 4'd10, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge Clk);
    #1 chk("rwStall", 32'(StallM), 32'h1);
    Rst = 1'b0;
    #1;
    chk("rwStall0", 32'(StallM), 32'h0);
    chk("rwRegWrite0", 32'(RegWriteW), 32'h0);
    chk("rwPCSrc0", 32'(PCSrcW), 32'h0);
    chk("rwWA30", 32'(WA3W), 32'h0);
    chk("rwResult0", ResultW, 32'h0);
    chk("rwTimeout0", 32'(LoadTimeout), 32'h0);
    @(negedge Clk); idle(); Rst = 1'b1;
    @(negedge Clk);
    chk("rwNoRetire", 32'(RegWriteW), 32'h0);
    #1 chk("rwIdle", 32'(StallM), 32'h0);
    // randomized run against the reference model
    @(negedge Clk); Rst = 1'b0;
    @(negedge Clk); Rst = 1'b1;
    pend = 0; waited = 0; eStall = 0; eRw = 0; ePc = 0; eTo = 0; eWa = 0; eRes = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clk);
      chk("rndRegWrite", 32'(RegWriteW), 32'(eRw));
      chk("rndPCSrc", 32'(PCSrcW), 32'(ePc));
      chk("rndWA3", 32'(WA3W), 32'(eWa));
      chk("rndResult", ResultW, eRes);
      chk("rndTimeout", 32'(LoadTimeout), 32'(eTo));
      if (!eStall) begin
        ValidM = $urandom_range(0, 3) != 0; ALUResultM = $urandom; WA3M = 4'($urandom);
        RegWriteM = 1'($urandom); MemToRegM = 1'($urandom); PCSrcM = $urandom_range(0, 7) == 0;
        MemSizeM = 2'($urandom); LoadSignedM = 1'($urandom);
      end
      FlushW = $urandom_range(0, 15) == 0;
      MemRValid = pend ? $urandom_range(0, 7) == 0 : $urandom_range(0, 2) == 0;
      MemRData = $urandom;
      #1;
      eStall = FlushW ? 0 : !pend ? (ValidM && MemToRegM && !MemRValid) : (!MemRValid && waited < TO - 1);
      chk("rndStall", 32'(StallM), 32'(eStall));
      eRw = 0; ePc = 0;
      if (FlushW) pend = 0;
      else if (!pend) begin
        if (ValidM) begin
          if (!MemToRegM) retireTo(RegWriteM, PCSrcM, WA3M, ALUResultM);
          else if (MemRValid)
            retireTo(RegWriteM, PCSrcM, WA3M, refAlign(MemRData, ALUResultM[1:0], MemSizeM, LoadSignedM));
          else begin
            pend = 1; waited = 0;
            pOff = ALUResultM[1:0]; pSz = MemSizeM; pSg = LoadSignedM;
            pRw = RegWriteM; pPc = PCSrcM; pWa = WA3M;
          end
        end
      end else if (MemRValid) begin
        retireTo(pRw, pPc, pWa, refAlign(MemRData, pOff, pSz, pSg));
        pend = 0;
      end else if (waited == TO - 1) begin
        eTo = 1; pend = 0;
      end else waited++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
